// File: rtl/ft8_tx_sequencer.sv
// FT8 8-FSK transmit sequencer: buffers one frame of channel symbols and steps the tone
// index / phase increment once per SAMPLES_PER_SYMBOL sample ticks. Option: FT8_COSTAS_INSERT_EN.
module ft8_tx_sequencer #(
  parameter int unsigned SAMPLES_PER_SYMBOL = 1920,
  parameter logic [15:0] BASE_INC           = 16'd8738,
  parameter logic [15:0] TONE_STEP          = 16'd34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        sym_valid,
  input  logic [2:0]  sym_data,
  output logic        sym_ready,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        tone_valid,
  output logic [2:0]  tone,
  output logic [15:0] phase_inc,
  output logic [6:0]  sym_index
);

`ifdef FT8_COSTAS_INSERT_EN
  localparam int unsigned N = 58;
`else
  localparam int unsigned N = 79;
`endif
  localparam int unsigned IW       = $clog2(N);
  localparam logic [6:0]  N_SYM    = 7'(N);
  localparam logic [6:0]  LAST_SYM = 7'd78;
  localparam logic [15:0] SMP_LAST = 16'(SAMPLES_PER_SYMBOL - 1);

  typedef enum logic {IDLE, TX} state_t;
  state_t state_q, state_d;

  logic [2:0]  sym_buf [N];
  logic [6:0]  wr_cnt;
  logic [15:0] smp_cnt;
  logic [6:0]  sym_cnt;
  logic [2:0]  tone_q;
  logic [15:0] phase_q;
  logic        done_q;

  logic        accept, go, sym_end, frame_end;
  logic [6:0]  sel_idx;
  logic [2:0]  sel_tone;

`ifdef FT8_COSTAS_INSERT_EN
  logic [6:0]  costas_pos;

  function automatic logic [2:0] costas(input logic [2:0] p);
    case (p)
      3'd0:    costas = 3'd3;
      3'd1:    costas = 3'd1;
      3'd2:    costas = 3'd4;
      3'd3:    costas = 3'd0;
      3'd4:    costas = 3'd6;
      3'd5:    costas = 3'd5;
      default: costas = 3'd2;
    endcase
  endfunction
`endif

  // abort wins over every other action in the same cycle
  always_comb begin
    accept    = (state_q == IDLE) && sym_valid && (wr_cnt < N_SYM) && !abort;
    go        = (state_q == IDLE) && start && (wr_cnt == N_SYM) && !abort;
    sym_end   = (state_q == TX) && sample_tick && (smp_cnt == SMP_LAST) && !abort;
    frame_end = sym_end && (sym_cnt == LAST_SYM);
  end

  // Tone for the symbol that becomes current after this edge (clamped past the last symbol)
  always_comb begin
    if (go)                        sel_idx = '0;
    else if (sym_cnt == LAST_SYM)  sel_idx = LAST_SYM;
    else                           sel_idx = sym_cnt + 7'd1;
`ifdef FT8_COSTAS_INSERT_EN
    if (sel_idx >= 7'd72)      costas_pos = sel_idx - 7'd72;
    else if (sel_idx >= 7'd36) costas_pos = sel_idx - 7'd36;
    else                       costas_pos = sel_idx;
    if (costas_pos < 7'd7)     sel_tone = costas(3'(costas_pos));
    else if (sel_idx < 7'd36)  sel_tone = sym_buf[IW'(sel_idx - 7'd7)];
    else                       sel_tone = sym_buf[IW'(sel_idx - 7'd14)];
`else
    sel_tone = sym_buf[IW'(sel_idx)];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && (wr_cnt == N_SYM)) state_d = TX;
        TX:      if (frame_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sym_ready  = (state_q == IDLE) && (wr_cnt < N_SYM);
    busy       = (state_q == TX);
    tone_valid = (state_q == TX);
    done       = done_q;
    tone       = tone_q;
    phase_inc  = phase_q;
    sym_index  = sym_cnt;
  end

  always_ff @(posedge clk) begin
    if (accept) sym_buf[IW'(wr_cnt)] <= sym_data;
  end

  // sym_cnt stays on the last symbol at frame end so sym_index holds its final value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      smp_cnt <= '0;
      sym_cnt <= '0;
      tone_q  <= '0;
      phase_q <= BASE_INC;
      done_q  <= 1'b0;
    end else begin
      done_q <= frame_end;

      if (abort || frame_end) wr_cnt <= '0;
      else if (accept)        wr_cnt <= wr_cnt + 7'd1;

      if (go) begin
        smp_cnt <= '0;
        sym_cnt <= '0;
      end else if ((state_q == TX) && sample_tick && !abort) begin
        if (smp_cnt == SMP_LAST) begin
          smp_cnt <= '0;
          if (!frame_end) sym_cnt <= sym_cnt + 7'd1;
        end else begin
          smp_cnt <= smp_cnt + 16'd1;
        end
      end

      if (go || (sym_end && !frame_end)) begin
        tone_q  <= sel_tone;
        phase_q <= BASE_INC + 16'(sel_tone) * TONE_STEP;
      end
    end
  end

endmodule

// File: tb/tb_ft8_tx_sequencer.sv
// Self-checking bench for ft8_tx_sequencer: table vectors, directed frame/abort/reset
// sequences and random traffic against a tick-counting reference model.
module tb_ft8_tx_sequencer;
  localparam int S = 4;
`ifdef FT8_COSTAS_INSERT_EN
  localparam int N = 58;
`else
  localparam int N = 79;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        sym_valid = 1'b0;
  logic [2:0]  sym_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sym_ready, busy, done, tone_valid;
  logic [2:0]  tone;
  logic [15:0] phase_inc;
  logic [6:0]  sym_index;

  ft8_tx_sequencer #(.SAMPLES_PER_SYMBOL(S)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .tone_valid(tone_valid), .tone(tone), .phase_inc(phase_inc), .sym_index(sym_index)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc     = 0;

  // reference model: frame contents, transmit flag and total ticks since start
  int mbuf[$];
  bit m_tx = 0;
  bit m_done = 0;
  int m_ticks = 0;
  int m_tone = 0;
  int m_idx = 0;
  int costas_tab[7] = '{3, 1, 4, 0, 6, 5, 2};

  function automatic int exp_tone(input int k);
`ifdef FT8_COSTAS_INSERT_EN
    if ((k % 36) < 7) return costas_tab[k % 36];
    else if (k < 36)  return mbuf[k - 7];
    else              return mbuf[k - 14];
`else
    return mbuf[k];
`endif
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_tx = 0; mbuf.delete(); m_tone = 0; m_idx = 0; m_done = 0; m_ticks = 0;
      return;
    end
    m_done = 0;
    if (abort) begin
      m_tx = 0;
      mbuf.delete();
    end else if (!m_tx) begin
      if (start && mbuf.size() == N) begin
        m_tx = 1; m_ticks = 0; m_idx = 0; m_tone = exp_tone(0);
      end else if (sym_valid && mbuf.size() < N) begin
        mbuf.push_back(int'(sym_data));
      end
    end else if (sample_tick) begin
      m_ticks++;
      if (m_ticks == 79 * S) begin
        m_tx = 0; m_done = 1; mbuf.delete();
      end else if (m_ticks % S == 0) begin
        m_idx = m_ticks / S;
        m_tone = exp_tone(m_idx);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] ep;
    ep = 16'(8738 + 34 * m_tone);
    chk("sym_ready",  32'(sym_ready),  32'(!m_tx && mbuf.size() < N));
    chk("busy",       32'(busy),       32'(m_tx));
    chk("tone_valid", 32'(tone_valid), 32'(m_tx));
    chk("done",       32'(done),       32'(m_done));
    chk("tone",       32'(tone),       m_tone);
    chk("phase_inc",  32'(phase_inc),  32'(ep));
    chk("sym_index",  32'(sym_index),  m_idx);
  endtask

  task automatic cycle();
    if (sym_valid && sym_ready) acc++;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load(input int cnt, input int base);
    for (int i = 0; i < cnt; i++) begin
      sym_valid = 1'b1;
`ifdef FT8_COSTAS_INSERT_EN
      sym_data = 3'd7;
`else
      sym_data = 3'((base + i) % 8);
`endif
      cycle();
    end
    sym_valid = 1'b0;
  endtask

  typedef struct {
    logic sv; logic [2:0] sd; logic st; logic ab; logic tk;
    logic e_ready; logic e_busy; logic e_done;
  } vec_t;
  vec_t vt[6];

  initial begin
    int ticks, done_cnt;
    bit got;

    // sv sd st ab tk | ready busy done
    vt[0] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // start on empty buffer
    vt[1] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // tick in idle
    vt[2] = '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // abort beats write
    vt[3] = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // start with one symbol
    vt[5] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // abort empties buffer

    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("rst_ready", 32'(sym_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_phase", 32'(phase_inc), 8738);
    chk("rst_tone", 32'(tone), 0);

    for (int i = 0; i < 6; i++) begin
      sym_valid = vt[i].sv; sym_data = vt[i].sd; start = vt[i].st;
      abort = vt[i].ab; sample_tick = vt[i].tk;
      cycle();
      chk("vec_ready", 32'(sym_ready), 32'(vt[i].e_ready));
      chk("vec_busy",  32'(busy),      32'(vt[i].e_busy));
      chk("vec_done",  32'(done),      32'(vt[i].e_done));
      chk("vec_tv",    32'(tone_valid), 32'(vt[i].e_busy));
    end
    sym_valid = 0; start = 0; abort = 0; sample_tick = 0;

    // early start, then complete the buffer and start for real
    load(10, 0);
    start = 1'b1; cycle(); start = 1'b0;
    chk("early_start_busy", 32'(busy), 0);
    load(N - 10, 10);
    chk("full_ready", 32'(sym_ready), 0);
    start = 1'b1; cycle();
    chk("start_busy", 32'(busy), 1);
    chk("start_tv", 32'(tone_valid), 1);
    chk("start_idx", 32'(sym_index), 0);
`ifdef FT8_COSTAS_INSERT_EN
    chk("start_tone", 32'(tone), 3);
    chk("start_phase", 32'(phase_inc), 8840);
`else
    chk("start_tone", 32'(tone), 0);
    chk("start_phase", 32'(phase_inc), 8738);
`endif

    // full frame with start and sym_valid held high throughout
    sym_valid = 1'b1; sym_data = 3'd2;
    ticks = 0; got = 0;
    for (int c = 0; c < 3000; c++) begin
      sample_tick = (c % 3 == 0);
      if (sample_tick) ticks++;
      cycle();
      if (sym_index == 7'd20) begin
`ifdef FT8_COSTAS_INSERT_EN
        chk("data_phase", 32'(phase_inc), 8976);
`else
        chk("sym20_phase", 32'(phase_inc), 8738 + 34 * 4);
`endif
      end
      if (done) begin got = 1; break; end
    end
    chk("frame_done_seen", 32'(got), 1);
    chk("done_tick", ticks, 79 * S);
    chk("done_busy", 32'(busy), 0);
    chk("done_ready", 32'(sym_ready), 1);
    chk("end_idx", 32'(sym_index), 78);
    acc = 0;
    done_cnt = 1;
    for (int c = 0; c < 3; c++) begin
      sample_tick = (c % 3 == 0);
      cycle();
      if (done) done_cnt++;
    end
    chk("done_pulses", done_cnt, 1);
    chk("start_in_done_ignored", 32'(busy), 0);
    start = 1'b0; sample_tick = 1'b0;

    // backpressure: continuous valid gives exactly N accepts
    for (int c = 0; c < N + 10; c++) begin
      sym_data = 3'($urandom_range(0, 7));
      cycle();
    end
    chk("bp_accepts", acc, N);
    chk("bp_ready", 32'(sym_ready), 0);

    // abort during symbol 40 together with tick and start
    start = 1'b1; cycle(); start = 1'b0;
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      sample_tick = (c % 3 == 0);
      cycle();
      if (m_idx == 40 && busy) begin got = 1; break; end
    end
    chk("reach_sym40", 32'(got), 1);
    abort = 1'b1; sample_tick = 1'b1; start = 1'b1;
    cycle();
    abort = 1'b0; sample_tick = 1'b0; start = 1'b0;
    chk("abort_tv", 32'(tone_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(sym_ready), 1);
    chk("abort_idx_hold", 32'(sym_index), 40);
    done_cnt = 0;
    acc = 0;
    for (int c = 0; c < N + 5; c++) begin
      cycle();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_wr_cleared", acc, N);

    // asynchronous reset in the middle of a frame
    sym_valid = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      sample_tick = (c % 3 == 0);
      cycle();
    end
    sample_tick = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tv", 32'(tone_valid), 0);
    chk("arst_tone", 32'(tone), 0);
    chk("arst_idx", 32'(sym_index), 0);
    chk("arst_phase", 32'(phase_inc), 8738);
    chk("arst_ready", 32'(sym_ready), 1);
    cycle();
    reset = 1'b0;
    cycle();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      sym_valid   = ($urandom_range(0, 3) != 0);
      sym_data    = 3'($urandom_range(0, 7));
      sample_tick = $urandom_range(0, 1) == 1;
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 599) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
